// File: rtl/prim_slice_serializer.sv
// rtl/prim_slice_serializer.sv - streams one InW-bit word as OutW-bit slices, LSB slice first
//
// A word is captured through the input valid/ready handshake. The held word is then
// presented one OutW-bit slice per handshake on the output side. The slice index
// runs from 0 to NumSlices-1. If InW is not a multiple of OutW, the last slice is
// zero-padded in its upper bits.
//
// Optional feature macro: PRIM_SLICE_SERIALIZER_PREFETCH_EN
//   When it is defined, a new word can be accepted in the same cycle as the
//   last-slice handshake, so back-to-back words stream with no bubble. This adds
//   a combinational path from ready_i to ready_o.
//   When it is undefined, words are accepted only in IDLE, which costs one bubble
//   per word.
//
// Ports:
//   clk_i    in   1       clock, all state on the rising edge
//   rst_i    in   1       asynchronous active-high reset
//   clear_i  in   1       synchronous abort; drops the held word and returns to IDLE
//   valid_i  in   1       input word valid
//   ready_o  out  1       input word accepted when valid_i & ready_o
//   data_i   in   InW     input word
//   valid_o  out  1       slice valid
//   ready_i  in   1       slice consumed when valid_o & ready_i
//   data_o   out  OutW    current slice, zero-padded above InW
//   idx_o    out  IndexW  index of the current slice
//   last_o   out  1       current slice is the final one of the word
module prim_slice_serializer #(
    parameter  int InW       = 64,
    parameter  int OutW      = 8,
    localparam int NumSlices = (InW + OutW - 1) / OutW,
    localparam int IndexW    = (NumSlices > 1) ? $clog2(NumSlices) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [InW-1:0]    data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [OutW-1:0]   data_o,
    output logic [IndexW-1:0] idx_o,
    output logic              last_o
);

    localparam int                PadW    = OutW * (2 ** IndexW);
    localparam logic [IndexW-1:0] LastIdx = IndexW'(NumSlices - 1);

    if (InW < 1) begin : g_bad_inw
        $error("prim_slice_serializer: InW must be >= 1");
    end
    if (OutW < 1) begin : g_bad_outw
        $error("prim_slice_serializer: OutW must be >= 1");
    end
    if (NumSlices > (2 ** IndexW)) begin : g_bad_idxw
        $error("prim_slice_serializer: NumSlices does not fit in IndexW");
    end

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [InW-1:0]    word_q, word_d;
    logic [IndexW-1:0] idx_q, idx_d;
    logic [PadW-1:0]   padded;
    logic              out_hs;
    logic              accept;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
        end
    end

    // Zero-extend the word so every index selects a full in-range slice.
    // This also supplies the padding of the final slice.
    assign padded = PadW'(word_q);
    assign data_o = padded[OutW * int'(idx_q) +: OutW];
    assign idx_o  = idx_q;

    always_comb begin
        valid_o = (state_q == SEND);
        last_o  = valid_o && (idx_q == LastIdx);
        out_hs  = valid_o && ready_i;
`ifdef PRIM_SLICE_SERIALIZER_PREFETCH_EN
        ready_o = !clear_i && ((state_q == IDLE) || (out_hs && last_o));
`else
        ready_o = !clear_i && (state_q == IDLE);
`endif
        accept  = valid_i && ready_o;

        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;

        if (clear_i) begin
            // The held word is left as is; it is never presented again.
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        word_d  = data_i;
                        idx_d   = '0;
                        state_d = SEND;
                    end
                end
                SEND: begin
                    if (out_hs) begin
                        if (last_o) begin
                            idx_d = '0;
                            if (accept) begin
                                // Prefetched word: continue in SEND without a bubble.
                                word_d = data_i;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // A stalled slice must not change until it is consumed.
    property p_hold_when_stalled;
        @(posedge clk_i) disable iff (rst_i)
            (valid_o && !ready_i && !clear_i) |=> ($stable(data_o) && $stable(idx_o));
    endproperty
    a_hold_when_stalled: assert property (p_hold_when_stalled);

endmodule

// File: tb/tb_prim_slice_serializer.sv
// tb/tb_prim_slice_serializer.sv - directed and random checks of prim_slice_serializer
module tb_prim_slice_serializer;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_clear, a_valid_in, a_ready_out, a_valid_out, a_ready_in, a_last;
    logic [63:0] a_data_in;
    logic [7:0]  a_data_out;
    logic [2:0]  a_idx;

    logic        b_clear, b_valid_in, b_ready_out, b_valid_out, b_ready_in, b_last;
    logic [19:0] b_data_in;
    logic [7:0]  b_data_out;
    logic [1:0]  b_idx;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    prim_slice_serializer #(.InW(64), .OutW(8)) dut_a (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (a_clear),
        .valid_i (a_valid_in),
        .ready_o (a_ready_out),
        .data_i  (a_data_in),
        .valid_o (a_valid_out),
        .ready_i (a_ready_in),
        .data_o  (a_data_out),
        .idx_o   (a_idx),
        .last_o  (a_last)
    );

    prim_slice_serializer #(.InW(20), .OutW(8)) dut_b (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (b_clear),
        .valid_i (b_valid_in),
        .ready_o (b_ready_out),
        .data_i  (b_data_in),
        .valid_o (b_valid_out),
        .ready_i (b_ready_in),
        .data_o  (b_data_out),
        .idx_o   (b_idx),
        .last_o  (b_last)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference slice: byte k of the word (LSB byte first)
    function automatic logic [7:0] slice64(input logic [63:0] w, input int k);
        return 8'((w >> (8 * k)) & 64'hFF);
    endfunction

    // Start of task: at a negedge with DUT A idle. End of task: at a negedge with DUT A idle.
    task automatic run_word(input logic [63:0] w, input int stall_at, input int stall_len);
        a_valid_in = 1'b1;
        a_data_in  = w;
        a_ready_in = 1'b1;
        #1 chk("word_ready_idle", a_ready_out, 1);
        @(negedge clk);
        a_valid_in = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == stall_at) begin
                a_ready_in = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    #1;
                    chk("stall_valid", a_valid_out, 1);
                    chk("stall_idx", a_idx, 64'(k));
                    chk("stall_data", a_data_out, slice64(w, k));
                    @(negedge clk);
                end
                a_ready_in = 1'b1;
            end
            #1;
            chk("word_valid", a_valid_out, 1);
            chk("word_idx", a_idx, 64'(k));
            chk("word_data", a_data_out, slice64(w, k));
            chk("word_last", a_last, (k == 7) ? 64'd1 : 64'd0);
            @(negedge clk);
        end
        #1;
        chk("word_end_valid", a_valid_out, 0);
        chk("word_end_ready", a_ready_out, 1);
    endtask

    initial begin
        logic [63:0] w;
        int          k;
        int          cycles;
        logic        r;
        logic        acc;
        logic        exp_v;
        logic [7:0]  exp_d;
        int          exp_i;

        rst = 1'b1;
        a_clear = 1'b0; a_valid_in = 1'b0; a_ready_in = 1'b0; a_data_in = '0;
        b_clear = 1'b0; b_valid_in = 1'b0; b_ready_in = 1'b0; b_data_in = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", a_valid_out, 0);
        chk("rst_ready", a_ready_out, 1);
        chk("rst_last", a_last, 0);
        chk("rst_idx", a_idx, 0);
        chk("rst_data", a_data_out, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Plain word, then a word stalled 5 cycles at index 3
        run_word(64'h0706050403020100, -1, 0);
        run_word(64'hF0E1D2C3B4A59687, 3, 5);

        // Clear in IDLE blocks acceptance
        a_clear = 1'b1; a_valid_in = 1'b1; a_data_in = 64'hDEAD;
        #1 chk("clr_idle_ready", a_ready_out, 0);
        @(negedge clk);
        a_clear = 1'b0; a_valid_in = 1'b0;
        #1 chk("clr_idle_valid", a_valid_out, 0);

        // Clear mid-word at index 2
        @(negedge clk);
        a_valid_in = 1'b1; a_data_in = 64'h8877665544332211; a_ready_in = 1'b1;
        @(negedge clk);
        a_valid_in = 1'b0;
        repeat (2) @(negedge clk);
        #1 chk("clr_pre_idx", a_idx, 2);
        a_clear = 1'b1;
        #1 chk("clr_ready", a_ready_out, 0);
        @(negedge clk);
        a_clear = 1'b0;
        #1;
        chk("clr_valid", a_valid_out, 0);
        chk("clr_ready_after", a_ready_out, 1);
        chk("clr_idx", a_idx, 0);
        @(negedge clk);
        run_word(64'h0123456789ABCDEF, -1, 0);

        // Asynchronous reset mid-word
        a_valid_in = 1'b1; a_data_in = 64'hCAFEBABE12345678; a_ready_in = 1'b1;
        @(negedge clk);
        a_valid_in = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", a_valid_out, 0);
        chk("arst_idx", a_idx, 0);
        chk("arst_ready", a_ready_out, 1);
        chk("arst_data", a_data_out, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1 chk("arst_no_residual", a_valid_out, 0);
        end

        // Back-to-back words
        @(negedge clk);
        a_valid_in = 1'b1; a_data_in = {8{8'h11}}; a_ready_in = 1'b1;
        @(negedge clk);
        a_data_in = {8{8'h22}};
        for (int c = 0; c < 18; c++) begin
`ifdef PRIM_SLICE_SERIALIZER_PREFETCH_EN
            exp_v = (c < 16);
            exp_d = (c < 8) ? 8'h11 : 8'h22;
            exp_i = c % 8;
`else
            exp_v = (c != 8) && (c < 17);
            exp_d = (c < 8) ? 8'h11 : 8'h22;
            exp_i = (c < 8) ? c : c - 9;
`endif
            #1;
            acc = a_valid_in && a_ready_out;
            chk("b2b_valid", a_valid_out, 64'(exp_v));
            if (exp_v) begin
                chk("b2b_data", a_data_out, 64'(exp_d));
                chk("b2b_idx", a_idx, 64'(exp_i));
            end
            @(negedge clk);
            if (acc && c > 0) a_valid_in = 1'b0;
        end
        a_valid_in = 1'b0;
        repeat (2) @(negedge clk);

        // Random words with random output backpressure
        for (int n = 0; n < 20; n++) begin
            w = {$urandom, $urandom};
            a_valid_in = 1'b1; a_data_in = w;
            #1 chk("rnd_ready", a_ready_out, 1);
            @(negedge clk);
            a_valid_in = 1'b0;
            k = 0;
            cycles = 0;
            while (k < 8 && cycles < 200) begin
                r = 1'($urandom_range(0, 1));
                a_ready_in = r;
                #1;
                chk("rnd_valid", a_valid_out, 1);
                chk("rnd_idx", a_idx, 64'(k));
                chk("rnd_data", a_data_out, slice64(w, k));
                chk("rnd_last", a_last, (k == 7) ? 64'd1 : 64'd0);
                @(negedge clk);
                if (r) k++;
                cycles++;
            end
            chk("rnd_done", 64'(k), 8);
            a_ready_in = 1'b1;
            #1 chk("rnd_idle", a_valid_out, 0);
            @(negedge clk);
        end

        // Fractional width: InW=20, OutW=8
        b_valid_in = 1'b1; b_data_in = 20'hABCDE; b_ready_in = 1'b1;
        @(negedge clk);
        b_valid_in = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("frac_valid", b_valid_out, 1);
            chk("frac_idx", b_idx, 64'(s));
            chk("frac_data", b_data_out, (s == 0) ? 64'hDE : (s == 1) ? 64'hBC : 64'h0A);
            chk("frac_last", b_last, (s == 2) ? 64'd1 : 64'd0);
            @(negedge clk);
        end
        #1;
        chk("frac_end_valid", b_valid_out, 0);
        chk("frac_end_ready", b_ready_out, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
